// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, single-request instruction memory port,
// one-entry hold buffer and the IF/ID pipeline register, with stall and redirect handling.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_disenabler_i,
  input  logic        IFID_disenabler_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_IFID_o,
  output logic [31:0] pc4_IFID_o,
  output logic        valid_IFID_o,
  output logic        fetch_busy_o
);

  typedef enum logic [1:0] {S_RESET, S_FETCH, S_KILL, S_FULL} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] buf_q, buf_d;

  logic        stall;
  logic        redirect;
  logic [31:0] pc_plus4;
  logic [31:0] target;

  assign stall    = PC_disenabler_i | IFID_disenabler_i;
  assign redirect = branch_taken_i & ~stall;
  assign pc_plus4 = pc_q + 32'd4;
  assign target   = branch_target_i & ~32'd3;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    pend_d  = pend_q;
    buf_d   = buf_q;

    case (state_q)
      S_RESET: begin
        state_d = S_FETCH;
        if (redirect) begin
          pc_d    = target;
          instr_d = 32'd0;
          valid_d = 1'b0;
        end
      end

      S_FETCH: begin
        if (imem_ready_i) begin
          if (stall) begin
            buf_d   = imem_rdata_i;
            state_d = S_FULL;
          end else if (redirect) begin
            pc_d    = target;
            instr_d = 32'd0;
            valid_d = 1'b0;
          end else begin
            instr_d = imem_rdata_i;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
          end
        end else if (redirect) begin
          // The outstanding request must complete at its original address first.
          pend_d  = target;
          instr_d = 32'd0;
          valid_d = 1'b0;
          state_d = S_KILL;
        end else if (!stall) begin
          instr_d = 32'd0;
          valid_d = 1'b0;
        end
      end

      S_KILL: begin
        instr_d = 32'd0;
        valid_d = 1'b0;
        if (redirect) pend_d = target;
        if (imem_ready_i) begin
          pc_d    = redirect ? target : pend_q;
          state_d = S_FETCH;
        end
      end

      S_FULL: begin
        if (redirect) begin
          pc_d    = target;
          instr_d = 32'd0;
          valid_d = 1'b0;
          state_d = S_FETCH;
        end else if (!stall) begin
          instr_d = buf_q;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
          state_d = S_FETCH;
        end
      end

      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RESET;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      pend_q  <= 32'd0;
      buf_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      buf_q   <= buf_d;
    end
  end

  // Reset masks the request immediately so an abandoned fetch is not re-issued.
  assign imem_req_o   = ~reset & ((state_q == S_FETCH) | (state_q == S_KILL));
  assign fetch_busy_o = imem_req_o & ~imem_ready_i;
  assign imem_addr_o  = pc_q;
  assign pc_o         = pc_q;
  assign instr_IFID_o = instr_q;
  assign pc4_IFID_o   = pc4_q;
  assign valid_IFID_o = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Table-driven bench for fetch_stage: per-cycle vectors with expected post-edge
// state pushed to a scoreboard queue and popped when the outputs are sampled.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        PC_disenabler_i;
  logic        IFID_disenabler_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        imem_ready_i;
  logic [31:0] imem_rdata_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] pc_o;
  logic [31:0] instr_IFID_o;
  logic [31:0] pc4_IFID_o;
  logic        valid_IFID_o;
  logic        fetch_busy_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk              (clk),
    .reset            (reset),
    .PC_disenabler_i  (PC_disenabler_i),
    .IFID_disenabler_i(IFID_disenabler_i),
    .branch_taken_i   (branch_taken_i),
    .branch_target_i  (branch_target_i),
    .imem_ready_i     (imem_ready_i),
    .imem_rdata_i     (imem_rdata_i),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .pc_o             (pc_o),
    .instr_IFID_o     (instr_IFID_o),
    .pc4_IFID_o       (pc4_IFID_o),
    .valid_IFID_o     (valid_IFID_o),
    .fetch_busy_o     (fetch_busy_o)
  );

  typedef struct {
    logic        rst;
    logic        pcd;
    logic        ifd;
    logic        br;
    logic [31:0] tgt;
    logic        rdy;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        req;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  // Instruction word stored at a given address in the bench's memory model.
  function automatic logic [31:0] w(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic vec_t mk(input logic rst, pcd, ifd, br, input logic [31:0] tgt,
                              input logic rdy, input logic [31:0] pc, instr, pc4,
                              input logic valid, req);
    vec_t v;
    v.rst = rst; v.pcd = pcd; v.ifd = ifd; v.br = br; v.tgt = tgt; v.rdy = rdy;
    v.pc = pc; v.instr = instr; v.pc4 = pc4; v.valid = valid; v.req = req;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  initial begin
    vec_t v, e;
    reset = 1'b1; PC_disenabler_i = 1'b0; IFID_disenabler_i = 1'b0;
    branch_taken_i = 1'b0; branch_target_i = 32'd0; imem_ready_i = 1'b1; imem_rdata_i = 32'd0;

    vecs.push_back(mk(1,0,0,0,32'h0,1, 32'h0040_0000, 32'h0, 32'h0, 0, 0));
    vecs.push_back(mk(1,0,0,0,32'h0,1, 32'h0040_0000, 32'h0, 32'h0, 0, 0));
    vecs.push_back(mk(0,0,0,0,32'h0,1, 32'h0040_0000, 32'h0, 32'h0, 0, 1));
    vecs.push_back(mk(0,0,0,0,32'h0,1, 32'h0040_0004, w(32'h0040_0000), 32'h0040_0004, 1, 1));
    vecs.push_back(mk(0,0,0,0,32'h0,1, 32'h0040_0008, w(32'h0040_0004), 32'h0040_0008, 1, 1));
    vecs.push_back(mk(0,0,0,0,32'h0,1, 32'h0040_000C, w(32'h0040_0008), 32'h0040_000C, 1, 1));
    // load-use stall: word at 0x40000C parked in the buffer
    vecs.push_back(mk(0,1,1,0,32'h0,1, 32'h0040_000C, w(32'h0040_0008), 32'h0040_000C, 1, 0));
    vecs.push_back(mk(0,0,0,0,32'h0,1, 32'h0040_0010, w(32'h0040_000C), 32'h0040_0010, 1, 1));
    vecs.push_back(mk(0,0,0,0,32'h0,1, 32'h0040_0014, w(32'h0040_0010), 32'h0040_0014, 1, 1));
    // wait states: stalled hold, then bubble
    vecs.push_back(mk(0,0,1,0,32'h0,0, 32'h0040_0014, w(32'h0040_0010), 32'h0040_0014, 1, 1));
    vecs.push_back(mk(0,0,0,0,32'h0,0, 32'h0040_0014, 32'h0, 32'h0, 0, 1));
    vecs.push_back(mk(0,0,0,0,32'h0,1, 32'h0040_0018, w(32'h0040_0014), 32'h0040_0018, 1, 1));
    // branch with memory ready, misaligned target
    vecs.push_back(mk(0,0,0,1,32'h0040_0103,1, 32'h0040_0100, 32'h0, 32'h0, 0, 1));
    vecs.push_back(mk(0,0,0,0,32'h0,1, 32'h0040_0104, w(32'h0040_0100), 32'h0040_0104, 1, 1));
    // branch during wait states, re-redirect in kill, returning word dropped
    vecs.push_back(mk(0,0,0,1,32'h0040_0203,0, 32'h0040_0104, 32'h0, 32'h0, 0, 1));
    vecs.push_back(mk(0,0,0,0,32'h0,0, 32'h0040_0104, 32'h0, 32'h0, 0, 1));
    vecs.push_back(mk(0,0,0,1,32'h0040_0303,0, 32'h0040_0104, 32'h0, 32'h0, 0, 1));
    vecs.push_back(mk(0,0,0,0,32'h0,1, 32'h0040_0300, 32'h0, 32'h0, 0, 1));
    vecs.push_back(mk(0,0,0,0,32'h0,1, 32'h0040_0304, w(32'h0040_0300), 32'h0040_0304, 1, 1));
    // branch with stall is ignored; then branch out of the full state to the top of memory
    vecs.push_back(mk(0,1,0,1,32'h0,1, 32'h0040_0304, w(32'h0040_0300), 32'h0040_0304, 1, 0));
    vecs.push_back(mk(0,0,0,1,32'hFFFF_FFFD,1, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 1));
    vecs.push_back(mk(0,0,0,0,32'h0,1, 32'h0000_0000, w(32'hFFFF_FFFC), 32'h0000_0000, 1, 1));
    vecs.push_back(mk(0,0,0,0,32'h0,1, 32'h0000_0004, w(32'h0000_0000), 32'h0000_0004, 1, 1));
    // reset taken while in kill
    vecs.push_back(mk(0,0,0,1,32'h0000_0100,0, 32'h0000_0004, 32'h0, 32'h0, 0, 1));
    vecs.push_back(mk(1,0,0,0,32'h0,1, 32'h0040_0000, 32'h0, 32'h0, 0, 0));
    vecs.push_back(mk(0,0,0,0,32'h0,1, 32'h0040_0000, 32'h0, 32'h0, 0, 1));
    vecs.push_back(mk(0,0,0,0,32'h0,1, 32'h0040_0004, w(32'h0040_0000), 32'h0040_0004, 1, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      reset = v.rst; PC_disenabler_i = v.pcd; IFID_disenabler_i = v.ifd;
      branch_taken_i = v.br; branch_target_i = v.tgt; imem_ready_i = v.rdy;
      imem_rdata_i = w(imem_addr_o);
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("pc", i, pc_o, e.pc);
      chk("addr", i, imem_addr_o, e.pc);
      chk("instr", i, instr_IFID_o, e.instr);
      chk("valid", i, {31'd0, valid_IFID_o}, {31'd0, e.valid});
      chk("req", i, {31'd0, imem_req_o}, {31'd0, e.req});
      chk("busy", i, {31'd0, fetch_busy_o}, {31'd0, e.req & ~e.rdy & ~e.rst});
      if (e.valid || e.rst) chk("pc4", i, pc4_IFID_o, e.pc4);
      $display("vec %0d rst=%0b stall=%0b%0b br=%0b rdy=%0b -> pc=%h instr=%h pc4=%h v=%0b req=%0b",
               i, v.rst, v.pcd, v.ifd, v.br, v.rdy, pc_o, instr_IFID_o, pc4_IFID_o, valid_IFID_o, imem_req_o);
    end

    // Reset held against arbitrary activity on every other input.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      reset = 1'b1;
      PC_disenabler_i = 1'($urandom_range(0, 1));
      IFID_disenabler_i = 1'($urandom_range(0, 1));
      branch_taken_i = 1'b1;
      branch_target_i = $urandom;
      imem_ready_i = 1'($urandom_range(0, 1));
      imem_rdata_i = $urandom;
      @(posedge clk);
      #1;
      chk("rst_pc", 100 + k, pc_o, 32'h0040_0000);
      chk("rst_valid", 100 + k, {31'd0, valid_IFID_o}, 32'd0);
      chk("rst_instr", 100 + k, instr_IFID_o, 32'd0);
      chk("rst_req", 100 + k, {31'd0, imem_req_o}, 32'd0);
      chk("rst_busy", 100 + k, {31'd0, fetch_busy_o}, 32'd0);
      $display("reset hold %0d -> pc=%h v=%0b req=%0b busy=%0b", k, pc_o, valid_IFID_o, imem_req_o, fetch_busy_o);
    end

    // First cycle after release: no request is issued.
    @(negedge clk);
    reset = 1'b0; branch_taken_i = 1'b0; PC_disenabler_i = 1'b0; IFID_disenabler_i = 1'b0;
    imem_ready_i = 1'b1;
    #1;
    chk("reset_cycle_req", 200, {31'd0, imem_req_o}, 32'd0);
    $display("release cycle -> req=%0b", imem_req_o);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
